// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: memory-indirect jump read handshake between the PC sequencer and data memory.
interface pc_sequencer_if #(parameter int WIDTH = 32);
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_valid;
    modport master (output mem_req, mem_addr, input mem_rdata, mem_valid);
    modport slave  (input mem_req, mem_addr, output mem_rdata, mem_valid);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection, Z/N flags, memory-indirect jump handshake and redirect flush.
// Define FLAG_BYPASS_EN to let a same-cycle flag write steer the branch condition.
module pc_sequencer #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             stall,
    input  logic             jump,
    input  logic             jump_mem,
    input  logic             branch_zero,
    input  logic             branch_neg,
    input  logic [WIDTH-1:0] target,
    input  logic             flag_wr,
    input  logic             alu_zero,
    input  logic             alu_neg,
    pc_sequencer_if.master   mem,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_link,
    output logic             flush,
    output logic             busy,
    output logic             z_flag,
    output logic             n_flag
);
    typedef enum logic {RUN, JM_WAIT} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] pc_nx, addr_nx;
    logic             req_nx, flush_nx, z_use, n_use;

`ifdef FLAG_BYPASS_EN
    assign z_use = flag_wr ? alu_zero : z_flag;
    assign n_use = flag_wr ? alu_neg  : n_flag;
`else
    assign z_use = z_flag;
    assign n_use = n_flag;
`endif

    assign pc_link = pc + 1'b1;
    assign busy    = state == JM_WAIT;

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        addr_nx  = mem.mem_addr;
        req_nx   = mem.mem_req;
        flush_nx = 1'b0;
        if (state == JM_WAIT) begin
            if (mem.mem_valid) begin
                pc_nx    = mem.mem_rdata;
                flush_nx = 1'b1;
                req_nx   = 1'b0;
                state_nx = RUN;
            end
        end else if (!stall) begin
            if (jump_mem) begin
                addr_nx  = target;
                req_nx   = 1'b1;
                state_nx = JM_WAIT;
            end else if (jump || (branch_zero && z_use) || (branch_neg && n_use)) begin
                pc_nx    = target;
                flush_nx = 1'b1;
            end else begin
                pc_nx = pc + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= RUN;
            pc           <= RESET_PC;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            flush        <= 1'b0;
            z_flag       <= 1'b0;
            n_flag       <= 1'b0;
        end else begin
            state        <= state_nx;
            pc           <= pc_nx;
            mem.mem_req  <= req_nx;
            mem.mem_addr <= addr_nx;
            flush        <= flush_nx;
            if (flag_wr) begin
                z_flag <= alu_zero;
                n_flag <= alu_neg;
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of sequencing, redirects, flags, JM handshake and reset.
module tb_pc_sequencer;
    localparam int W = 16;
    logic         clock = 1'b0;
    logic         resetn, stall, jump, jump_mem, branch_zero, branch_neg;
    logic         flag_wr, alu_zero, alu_neg;
    logic [W-1:0] target, pc, pc_link;
    logic         flush, busy, z_flag, n_flag;
    int           n_cmp = 0;
    int           n_err = 0;

    pc_sequencer_if #(.WIDTH(W)) m ();

    pc_sequencer #(.WIDTH(W), .RESET_PC('0)) dut (
        .clock(clock), .resetn(resetn), .stall(stall), .jump(jump), .jump_mem(jump_mem),
        .branch_zero(branch_zero), .branch_neg(branch_neg), .target(target),
        .flag_wr(flag_wr), .alu_zero(alu_zero), .alu_neg(alu_neg), .mem(m.master),
        .pc(pc), .pc_link(pc_link), .flush(flush), .busy(busy), .z_flag(z_flag), .n_flag(n_flag)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        stall = 0; jump = 0; jump_mem = 0; branch_zero = 0; branch_neg = 0;
        flag_wr = 0; alu_zero = 0; alu_neg = 0; target = '0;
        m.mem_valid = 0; m.mem_rdata = '0;
    endtask

    task automatic test_reset();
        idle();
        resetn = 0;
        tick(); tick();
        n_cmp++; if (pc !== 16'h0000) begin n_err++; $display("FAIL reset_pc got %h exp %h", pc, 16'h0000); end
        n_cmp++; if ({flush, busy, z_flag, n_flag, m.mem_req} !== 5'b0) begin n_err++; $display("FAIL reset_ctl got %b exp 00000", {flush, busy, z_flag, n_flag, m.mem_req}); end
        n_cmp++; if (m.mem_addr !== 16'h0000) begin n_err++; $display("FAIL reset_addr got %h exp 0000", m.mem_addr); end
        resetn = 1;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++; if (pc !== W'(i)) begin n_err++; $display("FAIL seq_pc got %h exp %h", pc, W'(i)); end
            n_cmp++; if (pc_link !== W'(i + 1)) begin n_err++; $display("FAIL seq_link got %h exp %h", pc_link, W'(i + 1)); end
            n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL seq_flush got %b exp 0", flush); end
        end
    endtask

    task automatic test_wrap_jump();
        jump = 1; target = 16'hFFFF;
        tick();
        jump = 0;
        n_cmp++; if ({pc, flush} !== {16'hFFFF, 1'b1}) begin n_err++; $display("FAIL jump_ffff got %h/%b exp ffff/1", pc, flush); end
        n_cmp++; if (pc_link !== 16'h0000) begin n_err++; $display("FAIL link_wrap got %h exp 0000", pc_link); end
        tick();
        n_cmp++; if ({pc, flush} !== {16'h0000, 1'b0}) begin n_err++; $display("FAIL wrap got %h/%b exp 0000/0", pc, flush); end
        jump = 1; target = 16'h0040;
        tick();
        jump = 0;
        n_cmp++; if ({pc, flush} !== {16'h0040, 1'b1}) begin n_err++; $display("FAIL jump_40 got %h/%b exp 0040/1", pc, flush); end
        tick();
        n_cmp++; if ({pc, flush} !== {16'h0041, 1'b0}) begin n_err++; $display("FAIL after_jump got %h/%b exp 0041/0", pc, flush); end
    endtask

    task automatic test_branch_zero();
        flag_wr = 1; alu_zero = 1; alu_neg = 0;
        tick();
        flag_wr = 0; alu_zero = 0;
        n_cmp++; if ({z_flag, n_flag} !== 2'b10) begin n_err++; $display("FAIL zflag_set got %b exp 10", {z_flag, n_flag}); end
        n_cmp++; if (pc !== 16'h0042) begin n_err++; $display("FAIL flag_cycle_pc got %h exp 0042", pc); end
        branch_zero = 1; target = 16'h0100;
        tick();
        branch_zero = 0;
        n_cmp++; if ({pc, flush} !== {16'h0100, 1'b1}) begin n_err++; $display("FAIL brz_taken got %h/%b exp 0100/1", pc, flush); end
        flag_wr = 1; alu_zero = 0;
        tick();
        flag_wr = 0;
        n_cmp++; if ({pc, z_flag} !== {16'h0101, 1'b0}) begin n_err++; $display("FAIL zflag_clr got %h/%b exp 0101/0", pc, z_flag); end
        branch_zero = 1; target = 16'h0200;
        tick();
        branch_zero = 0;
        n_cmp++; if ({pc, flush} !== {16'h0102, 1'b0}) begin n_err++; $display("FAIL brz_untaken got %h/%b exp 0102/0", pc, flush); end
    endtask

    task automatic test_bypass();
        logic [W-1:0] exp_pc;
`ifdef FLAG_BYPASS_EN
        exp_pc = 16'h0020;
`else
        exp_pc = 16'h0103;
`endif
        flag_wr = 1; alu_neg = 1; branch_neg = 1; target = 16'h0020;
        tick();
        idle();
        n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL bypass_pc got %h exp %h", pc, exp_pc); end
        n_cmp++; if (n_flag !== 1'b1) begin n_err++; $display("FAIL nflag_set got %b exp 1", n_flag); end
        branch_neg = 1; target = 16'h0050;
        tick();
        branch_neg = 0;
        n_cmp++; if ({pc, flush} !== {16'h0050, 1'b1}) begin n_err++; $display("FAIL brn_taken got %h/%b exp 0050/1", pc, flush); end
    endtask

    task automatic test_stall();
        stall = 1; jump = 1; target = 16'h0077; flag_wr = 1; alu_zero = 1; alu_neg = 0;
        tick();
        idle();
        n_cmp++; if ({pc, flush} !== {16'h0050, 1'b0}) begin n_err++; $display("FAIL stall_hold got %h/%b exp 0050/0", pc, flush); end
        n_cmp++; if ({z_flag, n_flag} !== 2'b10) begin n_err++; $display("FAIL stall_flags got %b exp 10", {z_flag, n_flag}); end
    endtask

    task automatic test_jump_mem();
        jump_mem = 1; target = 16'h0030;
        tick();
        jump_mem = 0;
        m.mem_rdata = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({m.mem_req, busy, m.mem_addr, pc, flush} !== {1'b1, 1'b1, 16'h0030, 16'h0050, 1'b0})
                begin n_err++; $display("FAIL jm_wait%0d got req=%b busy=%b addr=%h pc=%h flush=%b exp 1 1 0030 0050 0", i, m.mem_req, busy, m.mem_addr, pc, flush); end
            stall = i[0]; jump = 1; branch_zero = 1; jump_mem = 1; target = 16'h0099;
            if (i == 4) begin stall = 1; m.mem_valid = 1; end
            if (i < 4) tick();
        end
        tick();
        idle();
        n_cmp++; if ({pc, flush, m.mem_req, busy} !== {16'h1234, 1'b1, 1'b0, 1'b0}) begin n_err++; $display("FAIL jm_done got %h/%b/%b/%b exp 1234/1/0/0", pc, flush, m.mem_req, busy); end
        m.mem_valid = 1; m.mem_rdata = 16'hDEAD;
        tick();
        n_cmp++; if ({pc, flush} !== {16'h1235, 1'b0}) begin n_err++; $display("FAIL run_valid_ignored got %h/%b exp 1235/0", pc, flush); end
        idle();
    endtask

    task automatic test_priority_reset();
        jump = 1; branch_zero = 1; target = 16'h0123;
        tick();
        n_cmp++; if ({pc, flush} !== {16'h0123, 1'b1}) begin n_err++; $display("FAIL jump_brz got %h/%b exp 0123/1", pc, flush); end
        jump_mem = 1; target = 16'h0060;
        tick();
        idle();
        n_cmp++; if ({busy, m.mem_addr, pc} !== {1'b1, 16'h0060, 16'h0123}) begin n_err++; $display("FAIL jm_priority got %b/%h/%h exp 1/0060/0123", busy, m.mem_addr, pc); end
        resetn = 0; m.mem_valid = 1; m.mem_rdata = 16'h5555;
        tick();
        resetn = 1; m.mem_valid = 0;
        n_cmp++; if ({pc, m.mem_req, busy, flush} !== {16'h0000, 3'b000}) begin n_err++; $display("FAIL jm_reset got %h/%b/%b/%b exp 0000/0/0/0", pc, m.mem_req, busy, flush); end
        tick();
        n_cmp++; if (pc !== 16'h0001) begin n_err++; $display("FAIL post_reset got %h exp 0001", pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap_jump();
        test_branch_zero();
        test_bypass();
        test_stall();
        test_jump_mem();
        test_priority_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
